// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: multi-lane pipeline stage register with valid/ready
// handshake, optional skid entry and exception flush.
// Build option: define PIPE_SKID_EN for the two-entry skid variant with a
// registered in_ready; leave it undefined for a single register with a
// combinational in_ready.
module pipe_stage_buf #(
  parameter int                 LANES         = 2,
  parameter int                 DATA_W        = 128,
  parameter logic [DATA_W-1:0]  RESET_PAYLOAD = {DATA_W{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready,
  output logic [1:0]              count
);

  // Occupancy doubles as the FSM state; ST_TWO is only reachable with the skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [LANES-1:0]        r_main_valid;
  logic [LANES*DATA_W-1:0] r_main_data;
  logic [LANES*DATA_W-1:0] w_in_masked;
  logic                    w_accept;
  logic                    w_fire;
  logic                    w_load_main_in;
  logic                    w_clear_main;
`ifdef PIPE_SKID_EN
  logic [LANES-1:0]        r_skid_valid;
  logic [LANES*DATA_W-1:0] r_skid_data;
  logic                    r_in_ready;
  logic                    w_load_main_skid;
  logic                    w_load_skid;
`endif

  // Bubble lanes carry the reset payload so downstream sees a clean NOP.
  for (genvar g = 0; g < LANES; g++) begin : g_mask
    assign w_in_masked[g*DATA_W +: DATA_W] =
      in_valid[g] ? in_data[g*DATA_W +: DATA_W] : RESET_PAYLOAD;
  end

  assign w_accept  = in_ready & (|in_valid);
  assign w_fire    = (|r_main_valid) & out_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign count     = r_state;

  // State register: reset and flush both return to EMPTY.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (rst || flush) r_state <= ST_EMPTY;
    else              r_state <= w_state_next;
  end

  // Next-state logic from the accept/fire handshake events.
  always_comb begin
    // NOTE: defaulting every always_comb output first prevents latch inference.
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_ONE;
`ifdef PIPE_SKID_EN
      ST_ONE: begin
        if (w_accept && !w_fire)      w_state_next = ST_TWO;
        else if (!w_accept && w_fire) w_state_next = ST_EMPTY;
      end
      ST_TWO:   if (w_fire) w_state_next = ST_ONE;
`else
      ST_ONE:   if (!w_accept && w_fire) w_state_next = ST_EMPTY;
`endif
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  // Datapath controls decoded from state and handshake events.
  always_comb begin
    w_load_main_in   = 1'b0;
    w_clear_main     = 1'b0;
`ifdef PIPE_SKID_EN
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: w_load_main_in = w_accept;
      ST_ONE: begin
        w_load_main_in = w_accept & w_fire;
        w_load_skid    = w_accept & ~w_fire;
        w_clear_main   = ~w_accept & w_fire;
      end
      ST_TWO:   w_load_main_skid = w_fire;
      default:  ;
    endcase
`else
    case (r_state)
      ST_EMPTY: w_load_main_in = w_accept;
      ST_ONE: begin
        // In this build accept in ONE implies the current group fires.
        w_load_main_in = w_accept;
        w_clear_main   = ~w_accept & w_fire;
      end
      default:  ;
    endcase
`endif
  end

  // Main register: drives the downstream stage; data holds when emptied.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_main_valid <= '0;
      r_main_data  <= {LANES{RESET_PAYLOAD}};
    end else if (w_load_main_in) begin
      r_main_valid <= in_valid;
      r_main_data  <= w_in_masked;
`ifdef PIPE_SKID_EN
    end else if (w_load_main_skid) begin
      r_main_valid <= r_skid_valid;
      r_main_data  <= r_skid_data;
`endif
    end else if (w_clear_main) begin
      r_main_valid <= '0;
    end
  end

`ifdef PIPE_SKID_EN
  // Skid register: catches the group accepted while main is stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_skid_valid <= '0;
      r_skid_data  <= {LANES{RESET_PAYLOAD}};
    end else if (w_load_skid) begin
      r_skid_valid <= in_valid;
      r_skid_data  <= w_in_masked;
    end
  end

  // Registered ready: low only when the stage will hold two groups.
  always_ff @(posedge clk) begin
    if (rst || flush) r_in_ready <= 1'b1;
    else              r_in_ready <= (w_state_next != ST_TWO);
  end

  assign in_ready = r_in_ready;
`else
  assign in_ready = ~(|r_main_valid) | out_ready;
`endif

endmodule
